// File: rtl/axis_udp_filter_pkg.sv
// Shared definitions for the UDP filter front end.
//  - AXIS_DATA_WIDTH / AXIS_STRB_WIDTH : fixed stream geometry (64-bit data, 8-bit strobe)
//  - arb_state_t                       : frame arbiter states
//  - beats_of(bytes)                   : number of 8-byte beats needed to carry 'bytes'
package axis_udp_filter_pkg;

    localparam int AXIS_DATA_WIDTH = 64;
    localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    function automatic int beats_of(input int bytes);
        return (bytes + AXIS_STRB_WIDTH - 1) / AXIS_STRB_WIDTH;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//  req     in  NUM_PORTS       request vector
//  rr_ptr  in  clog2(NUM_PORTS) highest-priority index this round
//  gnt_idx out clog2(NUM_PORTS) first requester at or after rr_ptr (cyclic)
//  gnt_any out 1               at least one request present
// The request vector is rotated so rr_ptr lands at position 0, a fixed
// priority encoder picks the lowest set bit, and the offset is rotated back.
module rr_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_idx,
    output logic                         gnt_any
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] req_rot;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       back_sum;

    // One extra bit on the sums so NUM_PORTS need not be a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            logic [IDX_W:0] src_sum;
            logic [IDX_W:0] src_idx;
            assign src_sum     = (IDX_W+1)'(gi) + {1'b0, rr_ptr};
            assign src_idx     = (src_sum >= (IDX_W+1)'(NUM_PORTS)) ?
                                 src_sum - (IDX_W+1)'(NUM_PORTS) : src_sum;
            assign req_rot[gi] = req[src_idx[IDX_W-1:0]];
        end
    endgenerate

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        offset = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign back_sum = {1'b0, offset} + {1'b0, rr_ptr};
    assign gnt_idx  = (back_sum >= (IDX_W+1)'(NUM_PORTS)) ?
                      IDX_W'(back_sum - (IDX_W+1)'(NUM_PORTS)) : back_sum[IDX_W-1:0];
    assign gnt_any  = |req;

endmodule

// File: rtl/axis_udp_filter_arb.sv
// Frame-level round-robin arbiter sharing one filter input between NUM_PORTS
// AXI-Stream sources. A source keeps the grant for a whole tlast-delimited
// frame. Frames longer than MAX_FRAME_SIZE bytes are cut at MAX_BEATS with a
// forced tlast and the remainder of the source frame is discarded.
//  axis_clk / axis_a_rst_n  clock, asynchronous active-low reset
//  en                       arbitration enable, only looked at between frames
//  s_axis_*                 NUM_PORTS packed source streams (source i at slice i)
//  m_axis_*                 single stream towards the filter
//  grant_valid / grant_idx  a frame is in progress / which source owns it
//  oversize                 one-cycle pulse on the truncating beat
module axis_udp_filter_arb
    import axis_udp_filter_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int MAX_FRAME_SIZE = 1518
) (
    input  logic                                   axis_clk,
    input  logic                                   axis_a_rst_n,
    input  logic                                   en,
    input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_STRB_WIDTH-1:0]   s_axis_tstrb,
    input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
    output logic [NUM_PORTS-1:0]                   s_axis_tready,
    output logic                                   m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [AXIS_STRB_WIDTH-1:0]             m_axis_tstrb,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic                                   grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]           grant_idx,
    output logic                                   oversize
);

    localparam int IDX_W     = $clog2(NUM_PORTS);
    localparam int MAX_BEATS = beats_of(MAX_FRAME_SIZE);
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]           arb_gnt_idx;
    logic                       arb_gnt_any;
    logic                       sel_tvalid;
    logic                       sel_tlast;
    logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
    logic [AXIS_STRB_WIDTH-1:0] sel_tstrb;
    logic                       last_slot;
    logic [IDX_W-1:0]           next_ptr;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .req     (s_axis_tvalid),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (arb_gnt_idx),
        .gnt_any (arb_gnt_any)
    );

    assign sel_tvalid = s_axis_tvalid[grant_idx_q];
    assign sel_tlast  = s_axis_tlast[grant_idx_q];
    assign sel_tdata  = s_axis_tdata[grant_idx_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign sel_tstrb  = s_axis_tstrb[grant_idx_q*AXIS_STRB_WIDTH +: AXIS_STRB_WIDTH];

    // Beat currently offered is the last one allowed through.
    assign last_slot  = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
    assign next_ptr   = (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;

    assign grant_valid = (state_q != IDLE);
    assign grant_idx   = grant_idx_q;

    always_ff @(posedge axis_clk or negedge axis_a_rst_n) begin
        if (!axis_a_rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        beat_cnt_d    = beat_cnt_q;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tlast  = 1'b0;
        oversize      = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && arb_gnt_any) begin
                    grant_idx_d = arb_gnt_idx;
                    beat_cnt_d  = '0;
                    state_d     = PASS;
                end
            end

            PASS: begin
                m_axis_tvalid              = sel_tvalid;
                m_axis_tdata               = sel_tdata;
                m_axis_tstrb               = sel_tstrb;
                // Forced tlast is held for as long as the final slot is offered,
                // so it stays stable under backpressure.
                m_axis_tlast               = sel_tlast | last_slot;
                s_axis_tready[grant_idx_q] = m_axis_tready;
                if (sel_tvalid && m_axis_tready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_tlast) begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else if (last_slot) begin
                        oversize = 1'b1;
                        state_d  = DRAIN;
                    end
                end
            end

            DRAIN: begin
                s_axis_tready[grant_idx_q] = 1'b1;
                if (sel_tvalid && sel_tlast) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_udp_filter_arb.sv
// Directed bench for axis_udp_filter_arb (4 ports, 1518-byte frames / 190 beats).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_axis_udp_filter_arb;

    localparam int NP = 4;

    logic         axis_clk;
    logic         axis_a_rst_n;
    logic         en;
    logic [3:0]   s_tvalid;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [3:0]   s_tlast;
    logic [3:0]   s_tready;
    logic         m_tvalid;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tstrb;
    logic         m_tlast;
    logic         m_tready;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         oversize;

    int n_assert = 0;
    int n_fail   = 0;
    int ov_count = 0;

    axis_udp_filter_arb #(
        .NUM_PORTS      (NP),
        .MAX_FRAME_SIZE (1518)
    ) dut (
        .axis_clk      (axis_clk),
        .axis_a_rst_n  (axis_a_rst_n),
        .en            (en),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .oversize      (oversize)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int p, input logic v, input logic [63:0] d,
                           input logic [7:0] s, input logic l);
        s_tvalid[p]         = v;
        s_tdata[64*p +: 64] = d;
        s_tstrb[8*p +: 8]   = s;
        s_tlast[p]          = l;
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge axis_clk);
    endtask

    function automatic logic [95:0] all_outs();
        return {14'd0, m_tvalid, m_tdata, m_tstrb, m_tlast, s_tready,
                grant_valid, grant_idx, oversize};
    endfunction

    initial begin
        int exp_order [5];
        int beat;
        int cyc;
        exp_order = '{0, 1, 2, 3, 0};

        axis_a_rst_n = 1'b0;
        en           = 1'b1;
        m_tready     = 1'b1;
        s_tvalid     = '0;
        s_tdata      = '0;
        s_tstrb      = '0;
        s_tlast      = '0;

        // ---------------- reset ----------------
        repeat (2) @(posedge axis_clk);
        smp();
        chk("reset_outputs", all_outs(), 96'd0);
        tick();
        axis_a_rst_n = 1'b1;
        smp();
        chk("post_reset_outputs", all_outs(), 96'd0);

        // ---------------- test 1: port 0, 3-beat frame ----------------
        tick();
        set_src(0, 1'b1, 64'hD000, 8'hFF, 1'b0);
        smp();
        chk("t1_idle_latency", {m_tvalid, grant_valid}, 2'b00);
        tick();
        smp();
        chk("t1_b0", {m_tvalid, grant_idx, s_tready, m_tlast, m_tstrb, m_tdata},
            {1'b1, 2'd0, 4'b0001, 1'b0, 8'hFF, 64'hD000});
        tick();
        set_src(0, 1'b1, 64'hD001, 8'hFF, 1'b0);
        smp();
        chk("t1_b1", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 64'hD001});
        tick();
        set_src(0, 1'b1, 64'hD002, 8'h3F, 1'b1);
        smp();
        chk("t1_b2_last", {m_tvalid, m_tlast, m_tstrb, m_tdata}, {1'b1, 1'b1, 8'h3F, 64'hD002});
        tick();
        set_src(0, 1'b0, 64'h0, 8'h0, 1'b0);
        smp();
        chk("t1_back_idle", {grant_valid, m_tvalid}, 2'b00);

        // ---------------- test 2: all ports, 1-beat frames, rr_ptr=0 ----------------
        axis_a_rst_n = 1'b0;
        tick();
        axis_a_rst_n = 1'b1;
        for (int p = 0; p < NP; p++) begin
            set_src(p, 1'b1, 64'hA0 + 64'(p), 8'h01 << p, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            smp();
            chk($sformatf("t2_bubble_%0d", k), {grant_valid, m_tvalid}, 2'b00);
            tick();
            smp();
            chk($sformatf("t2_grant_%0d", k),
                {m_tvalid, grant_idx, s_tready, m_tlast, m_tstrb, m_tdata},
                {1'b1, 2'(exp_order[k]), 4'(1 << exp_order[k]), 1'b1,
                 8'(8'h01 << exp_order[k]), 64'hA0 + 64'(exp_order[k])});
            tick();
        end
        for (int p = 0; p < NP; p++) begin
            set_src(p, 1'b0, 64'h0, 8'h0, 1'b0);
        end
        smp();
        chk("t2_idle", {grant_valid, m_tvalid}, 2'b00);

        // ---------------- test 3: port 1, 200-beat frame, truncation ----------------
        set_src(1, 1'b1, 64'd0, 8'hFF, 1'b0);
        tick();
        for (int i = 0; i < 200; i++) begin
            set_src(1, 1'b1, 64'(i), 8'hFF, (i == 199));
            smp();
            if (oversize) ov_count++;
            if (i < 190) begin
                chk($sformatf("t3_pass_%0d", i),
                    {m_tvalid, grant_idx, m_tlast, oversize, m_tdata},
                    {1'b1, 2'd1, (i == 189), (i == 189), 64'(i)});
            end else begin
                chk($sformatf("t3_drain_%0d", i),
                    {m_tvalid, s_tready, grant_valid, oversize},
                    {1'b0, 4'b0010, 1'b1, 1'b0});
            end
            tick();
        end
        set_src(1, 1'b0, 64'h0, 8'h0, 1'b0);
        smp();
        chk("t3_idle", {grant_valid, m_tvalid}, 2'b00);
        chk("t3_oversize_count", 96'(ov_count), 96'd1);

        // ---------------- test 4: backpressure on port 2 ----------------
        set_src(2, 1'b1, 64'hC0, 8'h0F, 1'b0);
        tick();
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 20) begin
            m_tready = (cyc % 2 == 0);
            set_src(2, 1'b1, 64'hC0 + 64'(beat), 8'h0F, (beat == 3));
            smp();
            chk($sformatf("t4_cyc%0d", cyc),
                {m_tvalid, grant_idx, m_tlast, s_tready, m_tdata},
                {1'b1, 2'd2, (beat == 3), (m_tready ? 4'b0100 : 4'b0000),
                 64'hC0 + 64'(beat)});
            tick();
            if (m_tready) beat++;
            cyc++;
        end
        m_tready = 1'b1;
        set_src(2, 1'b0, 64'h0, 8'h0, 1'b0);
        smp();
        chk("t4_idle", {grant_valid, m_tvalid}, 2'b00);

        // ---------------- test 5: en dropped mid-frame ----------------
        set_src(2, 1'b1, 64'hE0, 8'hFF, 1'b0);
        tick();
        en = 1'b0;
        set_src(3, 1'b1, 64'hF3, 8'hFF, 1'b1);
        for (int b = 0; b < 3; b++) begin
            set_src(2, 1'b1, 64'hE0 + 64'(b), 8'hFF, (b == 2));
            smp();
            chk($sformatf("t5_port2_b%0d", b),
                {m_tvalid, grant_idx, m_tlast, m_tdata},
                {1'b1, 2'd2, (b == 2), 64'hE0 + 64'(b)});
            tick();
        end
        set_src(2, 1'b0, 64'h0, 8'h0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            smp();
            chk($sformatf("t5_hold_%0d", w), {grant_valid, m_tvalid, s_tready}, 6'd0);
            tick();
        end
        en = 1'b1;
        smp();
        chk("t5_still_idle", {grant_valid, m_tvalid}, 2'b00);
        tick();
        smp();
        chk("t5_port3", {m_tvalid, grant_idx, m_tlast, m_tdata},
            {1'b1, 2'd3, 1'b1, 64'hF3});
        tick();
        set_src(3, 1'b0, 64'h0, 8'h0, 1'b0);

        // ---------------- single requester: re-grant with one bubble ----------------
        set_src(1, 1'b1, 64'h11, 8'hFF, 1'b1);
        smp();
        chk("sr_idle0", grant_valid, 1'b0);
        tick();
        smp();
        chk("sr_grant0", {grant_valid, grant_idx, m_tdata}, {1'b1, 2'd1, 64'h11});
        tick();
        smp();
        chk("sr_bubble", {grant_valid, m_tvalid}, 2'b00);
        tick();
        smp();
        chk("sr_grant1", {grant_valid, grant_idx, m_tdata}, {1'b1, 2'd1, 64'h11});
        tick();
        set_src(1, 1'b0, 64'h0, 8'h0, 1'b0);

        // ---------------- test 6: reset in beat 2 ----------------
        set_src(2, 1'b1, 64'h20, 8'hFF, 1'b0);
        tick();
        smp();
        chk("t6_grant", {grant_valid, grant_idx, m_tdata}, {1'b1, 2'd2, 64'h20});
        tick();
        set_src(2, 1'b1, 64'h21, 8'hFF, 1'b0);
        smp();
        chk("t6_beat2", {m_tvalid, m_tdata}, {1'b1, 64'h21});
        #2;
        axis_a_rst_n = 1'b0;
        #1;
        chk("t6_reset_immediate", all_outs(), 96'd0);
        tick();
        chk("t6_reset_held", all_outs(), 96'd0);
        set_src(2, 1'b0, 64'h0, 8'h0, 1'b0);
        set_src(0, 1'b1, 64'h30, 8'hFF, 1'b1);
        set_src(3, 1'b1, 64'h33, 8'hFF, 1'b1);
        axis_a_rst_n = 1'b1;
        smp();
        chk("t6_idle_after", {grant_valid, m_tvalid}, 2'b00);
        tick();
        smp();
        chk("t6_regrant_port0", {m_tvalid, grant_idx, m_tdata}, {1'b1, 2'd0, 64'h30});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
